// File: rtl/ibpl_in_filt.sv
// Backplane input conditioning: 2-FF synchroniser, per-channel glitch filter with
// runtime length, inversion, enable gating, rise/fall events and stretched activity LEDs.
module ibpl_in_filt #(
  parameter int                   CHANNELS     = 6,
  parameter int                   FILTER_BITS  = 4,
  parameter int                   STRETCH_BITS = 16,
  parameter logic [CHANNELS-1:0]  INVERT_MASK  = '0
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [CHANNELS-1:0]    diob_in,
  output logic [CHANNELS-1:0]    diob_dir,
  output logic [CHANNELS-1:0]    diob_out,
  input  logic [FILTER_BITS-1:0] filt_len,
  input  logic [CHANNELS-1:0]    input_enable,
  input  logic [CHANNELS-1:0]    output_enable,
  output logic [CHANNELS-1:0]    internal_in,
  output logic [CHANNELS-1:0]    rise_evt,
  output logic [CHANNELS-1:0]    fall_evt,
  output logic [CHANNELS-1:0]    diob_led1,
  output logic [CHANNELS-1:0]    diob_led2,
  output logic                   plugin_error
);

  logic [CHANNELS-1:0] s1_q, s2_q;
  logic                plugin_error_q, plugin_error_d;

  assign diob_dir     = '0;
  assign diob_out     = '0;
  assign diob_led2    = input_enable;
  assign plugin_error = plugin_error_q;

  always_comb begin
    plugin_error_d = |(output_enable & ~input_enable);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1_q           <= '0;
      s2_q           <= '0;
      plugin_error_q <= 1'b0;
    end else begin
      s1_q           <= diob_in;
      s2_q           <= s1_q;
      plugin_error_q <= plugin_error_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic                    f_q, f_d;
    logic                    f_prev_q;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic [FILTER_BITS-1:0]  cnt_q, cnt_d;
    logic [STRETCH_BITS-1:0] led_q, led_d;
    logic                    lvl;

    assign lvl = f_q ^ INVERT_MASK[gi];

    always_comb begin
      f_d    = f_q;
      cnt_d  = cnt_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      led_d  = led_q;
      // >= so a shortened filt_len accepts on the next disagreeing cycle instead of wrapping
      if (s2_q[gi] == f_q) begin
        cnt_d = '0;
      end else if (cnt_q >= filt_len) begin
        f_d   = s2_q[gi];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + FILTER_BITS'(1);
      end
      // f_prev trails f by one cycle, so a difference means f changed last edge
      if (input_enable[gi] && (f_q != f_prev_q)) begin
        rise_d = lvl;
        fall_d = ~lvl;
      end
      if (rise_q || fall_q) begin
        led_d = '1;
      end else if (led_q != '0) begin
        led_d = led_q - STRETCH_BITS'(1);
      end
    end

    always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
        f_q      <= 1'b0;
        f_prev_q <= 1'b0;
        cnt_q    <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        led_q    <= '0;
      end else begin
        f_q      <= f_d;
        f_prev_q <= f_q;
        cnt_q    <= cnt_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        led_q    <= led_d;
      end
    end

    assign internal_in[gi] = input_enable[gi] & lvl;
    assign rise_evt[gi]    = rise_q;
    assign fall_evt[gi]    = fall_q;
    assign diob_led1[gi]   = (led_q != '0);
  end

endmodule

// File: tb/tb_ibpl_in_filt.sv
// Randomised and directed bench for ibpl_in_filt against a cycle-level behavioural model.
module tb_ibpl_in_filt;
  localparam int         CH      = 6;
  localparam int         FB      = 4;
  localparam int         SB      = 4;
  localparam logic [5:0] INV     = 6'b000010;
  localparam int         LED_MAX = (1 << SB) - 1;

  logic          clk = 1'b0;
  logic          nReset;
  logic [CH-1:0] diob_in, diob_dir, diob_out;
  logic [FB-1:0] filt_len;
  logic [CH-1:0] input_enable, output_enable;
  logic [CH-1:0] internal_in, rise_evt, fall_evt, diob_led1, diob_led2;
  logic          plugin_error;

  int n_vec = 0;
  int n_err = 0;

  // model state: sync pipeline, accepted level, disagreement run length, pending change
  bit [CH-1:0] m_s1, m_s2, m_f, m_chg, m_rise, m_fall;
  int          m_run [CH];
  int          m_led [CH];
  bit          m_perr;

  ibpl_in_filt #(
    .CHANNELS(CH), .FILTER_BITS(FB), .STRETCH_BITS(SB), .INVERT_MASK(INV)
  ) dut (
    .clk(clk), .nReset(nReset), .diob_in(diob_in), .diob_dir(diob_dir),
    .diob_out(diob_out), .filt_len(filt_len), .input_enable(input_enable),
    .output_enable(output_enable), .internal_in(internal_in), .rise_evt(rise_evt),
    .fall_evt(fall_evt), .diob_led1(diob_led1), .diob_led2(diob_led2),
    .plugin_error(plugin_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_f = '0; m_chg = '0; m_rise = '0; m_fall = '0; m_perr = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0;
      m_led[i] = 0;
    end
  endtask

  task automatic model_step();
    bit [CH-1:0] nr, nf;
    nr = '0; nf = '0;
    for (int i = 0; i < CH; i++) begin
      if (input_enable[i] && m_chg[i]) begin
        nr[i] = m_f[i] ^ INV[i];
        nf[i] = ~(m_f[i] ^ INV[i]);
      end
      if (m_rise[i] || m_fall[i]) m_led[i] = LED_MAX;
      else if (m_led[i] > 0)      m_led[i] = m_led[i] - 1;
      m_chg[i] = 1'b0;
      if (m_s2[i] == m_f[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] >= int'(filt_len)) begin
        m_f[i]   = m_s2[i];
        m_run[i] = 0;
        m_chg[i] = 1'b1;
      end else begin
        m_run[i] = m_run[i] + 1;
      end
    end
    m_rise = nr;
    m_fall = nf;
    m_s2   = m_s1;
    m_s1   = diob_in;
    m_perr = |(output_enable & ~input_enable);
  endtask

  task automatic check_all();
    bit [CH-1:0] led_exp;
    for (int i = 0; i < CH; i++) led_exp[i] = (m_led[i] != 0);
    chk("internal_in", 32'(internal_in), 32'(input_enable & (m_f ^ INV)));
    chk("rise_evt", 32'(rise_evt), 32'(m_rise));
    chk("fall_evt", 32'(fall_evt), 32'(m_fall));
    chk("led1", 32'(diob_led1), 32'(led_exp));
    chk("led2", 32'(diob_led2), 32'(input_enable));
    chk("plugin_error", 32'(plugin_error), 32'(m_perr));
    chk("dir_out", 32'({diob_dir, diob_out}), 32'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (nReset) model_step();
    #2;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_reset();
    nReset = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  initial begin
    int n;
    nReset        = 1'b0;
    diob_in       = '0;
    filt_len      = 4'd3;
    input_enable  = '1;
    output_enable = '0;
    #2;
    model_reset();
    check_all();
    chk("reset_internal", 32'(internal_in), 32'(6'b000010));
    #20;
    nReset = 1'b1;
    ticks(3);

    // clean rising edge on ch0: level latency, event position, LED stretch length
    diob_in[0] = 1'b1;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (internal_in[0]) begin n = k; break; end
    end
    chk("latency_ch0", 32'(n), 32'(6));
    tick();
    chk("rise_ch0", 32'(rise_evt[0]), 32'(1));
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (diob_led1[0]) n++;
      else if (n > 0) break;
    end
    chk("led_len_ch0", 32'(n), 32'(LED_MAX));

    // ch1 (inverted): 3-cycle pulse rejected, 4-cycle pulse accepted
    diob_in[1] = 1'b1; ticks(3);
    diob_in[1] = 1'b0; ticks(8);
    chk("reject_3clk", 32'(internal_in[1]), 32'(1));
    diob_in[1] = 1'b1; ticks(4);
    diob_in[1] = 1'b0; ticks(4);
    chk("accept_4clk", 32'(internal_in[1]), 32'(0));
    ticks(20);

    // disabled channel keeps filtering but shows nothing
    input_enable[2] = 1'b0;
    diob_in[2] = 1'b1; ticks(10);
    chk("disabled_lvl", 32'(internal_in[2]), 32'(0));
    input_enable[2] = 1'b1;
    #1;
    chk("reenable_lvl", 32'(internal_in[2]), 32'(1));
    tick();
    chk("reenable_noevt", 32'(rise_evt[2] | fall_evt[2]), 32'(0));
    ticks(3);

    // plugin error
    output_enable = 6'b000100;
    input_enable  = 6'b111011;
    tick();
    chk("perr_set", 32'(plugin_error), 32'(1));
    input_enable = '1;
    tick();
    chk("perr_clr", 32'(plugin_error), 32'(0));
    output_enable = '0;
    ticks(20);

    // reset mid count and mid stretch, then full latency after release
    filt_len   = 4'd5;
    diob_in[3] = 1'b1; ticks(10);
    diob_in[3] = 1'b0; ticks(4);
    chk("pre_reset_led", 32'(diob_led1[3]), 32'(1));
    pulse_reset();
    chk("reset_led", 32'(diob_led1), 32'(0));
    ticks(2);
    nReset     = 1'b1;
    diob_in[3] = 1'b1;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (internal_in[3]) begin n = k; break; end
    end
    chk("post_reset_latency", 32'(n), 32'(8));
    ticks(20);

    // randomised traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 7) == 0) diob_in[i] = ~diob_in[i];
      if ($urandom_range(0, 49) == 0) filt_len = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) input_enable = 6'($urandom);
      if ($urandom_range(0, 29) == 0) output_enable = 6'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
        ticks(1);
        nReset = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
